// File: rtl/imm_extend_pipe.sv
// Two-stage elastic immediate-extension pipeline: S1 captures the raw field,
// S2 holds the extended operand, and a tag rides along with every item.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic [1:0]       in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [1:0]       occupancy_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and a presented item holds its
    // data until it is taken. in_ready_o may follow out_ready_i in the same
    // cycle, out_valid_o comes straight from a register.

    logic             s1_valid;
    logic [IN_W-1:0]  s1_data;
    logic [1:0]       s1_mode;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [OUT_W-1:0] s2_data;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_free;
    logic             move;
    logic             accept;
    logic             s1_valid_nx;
    logic             s2_valid_nx;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;

    assign s2_free    = !s2_valid || out_ready_i;
    assign move       = s1_valid && s2_free;
    assign in_ready_o = !flush_i && (!s1_valid || s2_free);
    assign accept     = in_valid_i && in_ready_o;

    // A flush wins over every other update; a same-cycle pop is already consumed.
    assign s1_valid_nx = !flush_i && (accept || (s1_valid && !move));
    assign s2_valid_nx = !flush_i && (move || (s2_valid && !out_ready_i));

    always_comb begin
        sext = OUT_W'($signed(s1_data));
        ext  = '0;
        case (s1_mode)
            2'b00:   ext = sext;
            2'b01:   ext = OUT_W'(s1_data);
            2'b10:   ext = OUT_W'(s1_data) << (OUT_W - IN_W);
            default: ext = sext << SHIFT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_mode     <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            s2_tag      <= '0;
            occupancy_o <= '0;
        end else begin
            s1_valid    <= s1_valid_nx;
            s2_valid    <= s2_valid_nx;
            occupancy_o <= {1'b0, s1_valid_nx} + {1'b0, s2_valid_nx};
            if (accept) begin
                s1_data <= in_data_i;
                s1_mode <= in_mode_i;
                s1_tag  <= in_tag_i;
            end
            if (move) begin
                s2_data <= ext;
                s2_tag  <= s1_tag;
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign out_data_o  = s2_data;
    assign out_tag_o   = s2_tag;

endmodule
